// File: rtl/jk_drv_pkg.sv
// Shared types and command encodings for the JK bank driver.
// Commands are {j,k}; 2'b11 tristates the bank and is never issued.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_e;

  localparam logic [1:0] CMD_HOLD    = 2'b00;
  localparam logic [1:0] CMD_SET     = 2'b10;
  localparam logic [1:0] CMD_RESET   = 2'b01;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

  function automatic logic [1:0] cmd_for(input logic tgt_bit);
    return tgt_bit ? CMD_SET : CMD_RESET;
  endfunction

endpackage

// File: rtl/jk_change_picker.sv
// Combinational: selects the lowest-index set bits of pending_i, at most MAX_CHANGES of them.
// Zero latency; no flow control.
module jk_change_picker #(
  parameter int WIDTH       = 8,
  parameter int MAX_CHANGES = 2
) (
  input  logic [WIDTH-1:0] pending_i,
  output logic [WIDTH-1:0] sel_o
);

  int cnt;

  always_comb begin
    sel_o = '0;
    cnt   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pending_i[i] && (cnt < MAX_CHANGES)) begin
        sel_o[i] = 1'b1;
        cnt      = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flip-flops to a target word, at most MAX_CHANGES bits per cycle, then verifies readback.
// Latency: done pulses ceil(popcount(diff)/MAX_CHANGES)+2 cycles after transfer; tgt_ready is low while busy.
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MAX_CHANGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             rdy_q, rdy_d;

  logic             take;
  logic [WIDTH-1:0] pend_src;
  logic [WIDTH-1:0] tgt_word;
  logic [WIDTH-1:0] sel;
  logic             apply_go;
  logic             mismatch_w;
  logic [1:0]       cmd;

  // The picker looks at whatever must still be commanded next cycle:
  // the fresh diff on a transfer, otherwise the remaining pending bits.
  always_comb begin
    take     = tgt_valid && rdy_q && (state_q == IDLE);
    pend_src = take ? (tgt_data ^ shadow_q) : pending_q;
    tgt_word = take ? tgt_data : target_q;
  end

  jk_change_picker #(
    .WIDTH       (WIDTH),
    .MAX_CHANGES (MAX_CHANGES)
  ) u_picker (
    .pending_i (pend_src),
    .sel_o     (sel)
  );

  assign mismatch_w = (state_q == CHECK) && (q_in != shadow_q);

  always_comb begin
    state_d   = state_q;
    target_d  = tgt_word;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    j_d       = '0;
    k_d       = '0;
    rdy_d     = 1'b0;
    apply_go  = 1'b0;
    cmd       = CMD_HOLD;

    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (take) begin
          rdy_d = 1'b0;
          if (pend_src != '0) apply_go = 1'b1;
          else                state_d  = SETTLE;
        end
      end
      APPLY: begin
        if (pending_q != '0) apply_go = 1'b1;
        else                 state_d  = SETTLE;
      end
      SETTLE: state_d = CHECK;
      CHECK: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
        if (mismatch_w) shadow_d = q_in;
      end
      default: state_d = IDLE;
    endcase

    // Commands are registered so the bank sees them for exactly one cycle,
    // and the shadow tracks each group as it is issued.
    if (apply_go) begin
      state_d   = APPLY;
      pending_d = pend_src & ~sel;
      for (int i = 0; i < WIDTH; i++) begin
        cmd = sel[i] ? cmd_for(tgt_word[i]) : CMD_HOLD;
        if (cmd == CMD_ILLEGAL) cmd = CMD_HOLD;
        {j_d[i], k_d[i]} = cmd;
        if (sel[i]) shadow_d[i] = tgt_word[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      target_q  <= '0;
      pending_q <= '0;
      shadow_q  <= '0;
      j_q       <= '0;
      k_q       <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      j_q       <= j_d;
      k_q       <= k_d;
      rdy_q     <= rdy_d;
    end
  end

  assign j_out     = j_q;
  assign k_out     = k_q;
  assign tgt_ready = rdy_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == CHECK);
  assign mismatch  = mismatch_w;

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Initiator side of the SR/JK flip-flop command interface: accepts target words and generates the per-bit set/reset (J/K) commands that move a downstream bank of SR/JK flip-flops to the target value.
- Keeps a shadow copy of the bank state and limits the number of bits changed per cycle.
- After applying a word, reads back the bank outputs and flags any mismatch.
- Sits between register-write logic and a flip-flop bank.

Parameters:
- WIDTH, 8, number of flip-flops in the downstream bank.
- MAX_CHANGES, 2, maximum number of bits commanded (set or reset) per clock cycle; must be between 1 and WIDTH.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- tgt_valid  input  1  a target word is offered.
- tgt_data  input  WIDTH  target value for the bank.
- tgt_ready  output  1  driver can accept a target word.
- j_out  output  WIDTH  per-bit set command to the bank (registered).
- k_out  output  WIDTH  per-bit reset command to the bank (registered).
- q_in  input  WIDTH  bank q outputs, read back for checking.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a word is complete.
- mismatch  output  1  one-cycle pulse, coincident with done, when the readback differs from the shadow.

Behaviour:
- Reset (rst_n low, takes effect asynchronously):
  - state = IDLE; shadow = 0; pending = 0.
  - j_out = 0, k_out = 0, tgt_ready = 0, busy = 0, done = 0, mismatch = 0.
  - The bank must also be initialised to 0.
- tgt_ready is registered:
  - Rises in the first cycle after reset release.
  - Is high exactly while state = IDLE.
- Handshake:
  - A transfer occurs when tgt_valid and tgt_ready are both high at a posedge.
  - The upstream holds tgt_data stable while tgt_valid is high and tgt_ready is low.
- Command encoding per bit, {j,k}: 00 hold, 10 set, 01 reset.
  - 11 is illegal: it drives q to high-Z in the bank and must never be issued.
- State IDLE:
  - On transfer, latch target = tgt_data and pending = tgt_data XOR shadow.
  - If pending is nonzero, go to APPLY; otherwise go to SETTLE.
- State APPLY (one cycle per command group):
  - Select the lowest-index set bits of pending, at most MAX_CHANGES of them.
  - For each selected bit, drive j = target bit and k = NOT target bit.
  - Clear the selected bits from pending and copy the target bits into shadow.
  - Unselected bits are driven 00.
  - When pending becomes 0 after this cycle, go to SETTLE.
- State SETTLE:
  - j_out and k_out are 0.
  - The bank captured the last command at the preceding edge.
  - Go to CHECK.
- State CHECK:
  - done = 1.
  - mismatch = (q_in != shadow), combinational from q_in.
  - If there is a mismatch, shadow <= q_in (resynchronise).
  - Go to IDLE.
- Latency:
  - n = ceil(popcount(diff) / MAX_CHANGES).
  - Transfer edge = cycle 0; APPLY occupies cycles 1..n, SETTLE is cycle n+1, done is in cycle n+2.
  - With a zero diff, done is in cycle 2.
  - Next transfer is at the earliest in the cycle after done.
- Boundaries:
  - popcount exactly equal to MAX_CHANGES takes a single APPLY cycle.
  - All WIDTH bits changing takes ceil(WIDTH / MAX_CHANGES) APPLY cycles.
  - A single APPLY cycle may mix set and reset bits.
  - tgt_valid while busy is ignored until IDLE.
  - Reset mid-operation aborts immediately: commands drop to 00 and no done pulse is produced.

Decomposition:
- Package jk_drv_pkg:
  - State enum: IDLE, APPLY, SETTLE, CHECK.
  - Command constants: CMD_HOLD=2'b00, CMD_SET=2'b10, CMD_RESET=2'b01, CMD_ILLEGAL=2'b11.
- Sub-module jk_change_picker:
  - Combinational; takes pending[WIDTH] and outputs a select mask of the lowest-index set bits, at most MAX_CHANGES of them.
  - Instantiated once.

Test Plan:
All cases use WIDTH=8, MAX_CHANGES=2, and a behavioural SR bank model driven by j_out/k_out with q_in fed back.
- Release reset, send 0x00 -> tgt_ready rises in cycle 1 after release; no j/k activity; done in cycle 2 after transfer; mismatch=0.
- From 0x00, send 0x0F -> cycle 1: j=0x03, k=0x00; cycle 2: j=0x0C; done in cycle 4; q_in=0x0F; mismatch=0.
- From 0x0F, send 0xF0 -> k=0x03, k=0x0C, j=0x30, j=0xC0 over cycles 1-4; done in cycle 6; q_in=0xF0.
- Bank model with bit 7 stuck at 0, send 0x80 -> j=0x80 in cycle 1; CHECK sees q_in=0x00; done=1 and mismatch=1; shadow becomes 0x00, so resending 0x80 reissues j=0x80.
- Assert rst_n low during the second APPLY cycle of 0x0F -> j_out, k_out, busy and tgt_ready are 0 immediately; no done pulse; after release, sending 0x01 yields j=0x01 (shadow was 0).
- Hold tgt_valid with 0x55 while busy on a prior word -> accepted only in the cycle after done. Assertion throughout: (j_out AND k_out) == 0.
